// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: small FIFO that absorbs upstream pixels and releases one raster frame
// at the divided pixel rate, with x/y coordinates and sticky done/underflow flags.
module vga_pixel_feeder #(
   parameter int data_width  = 8,
   parameter int imageWidth  = 64,
   parameter int imageheight = 48,
   parameter int DIV         = 10,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  pix_en,
   output logic [data_width-1:0] pix_data,
   output logic [15:0]           pix_x,
   output logic [15:0]           pix_y,
   output logic                  frame_done,
   output logic                  underflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DIV);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                state;
   logic [data_width-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count;
   logic [DW-1:0]         div;
   logic [15:0]           nx, ny;
   logic                  push, pop, tick, x_wrap, last;
   assign in_ready = (count < CW'(FIFO_DEPTH)) && state != DONE;
   assign push     = in_valid && in_ready;
   assign tick     = state == RUN && div == DW'(DIV - 1);
   assign pop      = tick && count != '0;
   assign x_wrap   = nx == 16'(imageWidth - 1);
   assign last     = x_wrap && ny == 16'(imageheight - 1);
   // Storage needs no reset: count and pointers define what is valid.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         div        <= '0;
         nx         <= '0;
         ny         <= '0;
         pix_en     <= 1'b0;
         pix_data   <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         pix_en <= tick;
         wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(push) - CW'(pop);
         case (state)
            RUN: begin
               div <= tick ? '0 : div + DW'(1);
               if (tick) begin
                  // An empty tick still consumes the pixel slot so the raster stays aligned.
                  pix_data  <= pop ? mem[rd_ptr] : '0;
                  underflow <= underflow | ~pop;
                  pix_x     <= nx;
                  pix_y     <= ny;
                  nx        <= x_wrap ? '0 : nx + 16'd1;
                  ny        <= last ? '0 : (x_wrap ? ny + 16'd1 : ny);
                  if (last) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end
               end
            end
            default:
               if (start) begin
                  state      <= RUN;
                  frame_done <= 1'b0;
                  underflow  <= 1'b0;
                  div        <= '0;
                  nx         <= '0;
                  ny         <= '0;
               end
         endcase
      end
endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb_vga_pixel_feeder: directed stimulus with a queue scoreboard; a monitor checks every
// pix_en strobe (data, coordinates, flags, timing) against expected entries.
module tb_vga_pixel_feeder;
   localparam int DIV = 4, W = 4, H = 3, DEPTH = 4;
   logic        clk = 0, reset = 0, start = 0, in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, pix_en, frame_done, underflow;
   logic [7:0]  pix_data;
   logic [15:0] pix_x, pix_y;
   typedef struct packed {
      logic [7:0]  d;
      logic [15:0] x, y;
      logic        uf, fd, first;
   } exp_t;
   exp_t       exp_q[$];
   logic [7:0] feed_q[$];
   int         vec = 0, miss = 0, acc = 0;
   time        t_start = 0, t_last = 0;

   vga_pixel_feeder #(.data_width(8), .imageWidth(W), .imageheight(H), .DIV(DIV),
                      .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .pix_en(pix_en), .pix_data(pix_data), .pix_x(pix_x),
      .pix_y(pix_y), .frame_done(frame_done), .underflow(underflow));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      in_valid = feed_q.size() > 0;
      in_data  = in_valid ? feed_q[0] : 8'h00;
   endtask

   task automatic cycle();
      logic hs;
      @(negedge clk);
      hs = in_valid && in_ready && reset;
      @(posedge clk);
      #1;
      if (hs) begin
         void'(feed_q.pop_front());
         acc++;
      end
      start = 0;
      drive();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic go();
      start = 1;
      cycle();
      t_start = $time - 1;
   endtask

   task automatic feed(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) feed_q.push_back(base + 8'(i));
      drive();
   endtask

   task automatic expect_frame(input logic [7:0] base, input bit uf_first);
      exp_t e;
      for (int i = 0; i < W * H; i++) begin
         e.d     = uf_first ? (i == 0 ? 8'h00 : base + 8'(i - 1)) : base + 8'(i);
         e.x     = 16'(i % W);
         e.y     = 16'(i / W);
         e.uf    = uf_first;
         e.fd    = (i == W * H - 1);
         e.first = (i == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() > 0 && n < 400) begin
         cycle();
         n++;
      end
      check("frame_drained", exp_q.size(), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && pix_en) begin
            if (exp_q.size() == 0) check("spurious_strobe", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("pix_data", pix_data, e.d);
               check("pix_x", pix_x, e.x);
               check("pix_y", pix_y, e.y);
               check("underflow", underflow, e.uf);
               check("frame_done", frame_done, e.fd);
               if (e.first) check("first_strobe_latency", 32'($time - t_start), DIV * 10 + 5);
               else check("strobe_period", 32'($time - t_last), DIV * 10);
               t_last = $time;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stimulus
      cycles(2);
      check("rst_in_ready", in_ready, 1);
      check("rst_pix_en", pix_en, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_x", pix_x, 0);
      check("rst_pix_y", pix_y, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_underflow", underflow, 0);
      reset = 1;
      cycle();
      // prefill in IDLE until the FIFO is full, then run a frame fed in the background
      acc = 0;
      feed(8'h10, 12);
      cycles(8);
      check("accepted_when_full", acc, DEPTH);
      check("in_ready_full", in_ready, 0);
      check("idle_no_strobe_data", pix_data, 0);
      expect_frame(8'h10, 0);
      go();
      cycles(DIV);
      check("in_ready_after_pop", in_ready, 1);
      wait_done();
      check("done_frame_done", frame_done, 1);
      check("done_underflow", underflow, 0);
      check("done_in_ready", in_ready, 0);
      // restart from DONE with an ignored start in the middle of the frame
      feed(8'h80, 12);
      cycles(3);
      check("done_blocks_push", in_ready, 0);
      check("frame_done_held", frame_done, 1);
      expect_frame(8'h80, 0);
      go();
      check("frame_done_cleared", frame_done, 0);
      cycles(5);
      start = 1;
      cycle();
      wait_done();
      check("restart_frame_done", frame_done, 1);
      // underflow: empty FIFO, first pixel pushed on the exact tick cycle
      expect_frame(8'h30, 1);
      go();
      cycles(DIV - 1);
      feed(8'h30, 11);
      wait_done();
      check("uf_sticky", underflow, 1);
      check("uf_frame_done", frame_done, 1);
      // reset mid-frame after five strobes
      feed(8'h40, 12);
      expect_frame(8'h40, 0);
      go();
      cycles(5 * DIV + 2);
      check("strobes_before_reset", W * H - exp_q.size(), 5);
      reset = 0;
      #1;
      check("mid_rst_pix_en", pix_en, 0);
      check("mid_rst_pix_data", pix_data, 0);
      check("mid_rst_pix_x", pix_x, 0);
      check("mid_rst_pix_y", pix_y, 0);
      check("mid_rst_frame_done", frame_done, 0);
      check("mid_rst_underflow", underflow, 0);
      check("mid_rst_in_ready", in_ready, 1);
      exp_q.delete();
      feed_q.delete();
      drive();
      cycles(2);
      reset = 1;
      cycle();
      check("post_rst_idle_no_strobe", pix_en, 0);
      acc = 0;
      feed(8'h50, 12);
      cycles(6);
      check("refill_accepted", acc, DEPTH);
      expect_frame(8'h50, 0);
      go();
      wait_done();
      check("replay_frame_done", frame_done, 1);
      check("replay_underflow", underflow, 0);
      check("replay_last_x", pix_x, W - 1);
      check("replay_last_y", pix_y, H - 1);
      cycles(3);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/vga_pixel_feeder.md
# vga_pixel_feeder

Rate-matching buffer between the image-processing stage and `vga_controller`. It accepts processed 8-bit pixels from upstream over a valid/ready handshake and stores them in a small FIFO. It releases exactly one frame (`imageWidth*imageheight` pixels, raster order) at the divided pixel rate, with x/y coordinates, and flags frame completion and underflow. It replaces the free-running counter-indexed unload of the processed-data bus.

## Interface
- `data_width`, default 8: pixel width.
- `imageWidth`, default 64: pixels per line.
- `imageheight`, default 48: lines per frame.
- `DIV`, default 10: system clocks per pixel tick (50 MHz to 5 MHz). Legal range is 2 or more.
- `FIFO_DEPTH`, default 16: power of two, 4 or more.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle pulse; starts a frame.
- `in_data`  in  data_width  upstream pixel.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a pixel.
- `pix_en`  out  1  one-cycle strobe: new pixel on `pix_data`.
- `pix_data`  out  data_width  current pixel, held between strobes.
- `pix_x`  out  16  column of the current pixel.
- `pix_y`  out  16  row of the current pixel.
- `frame_done`  out  1  sticky; the full frame has been emitted.
- `underflow`  out  1  sticky; at least one tick found the FIFO empty.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- FIFO
  - Circular buffer with read/write pointers (log2(FIFO_DEPTH) bits, natural wrap) and an occupancy count (0..FIFO_DEPTH).
  - Push when `in_valid && in_ready`.
  - `in_ready = (count < FIFO_DEPTH) && state != DONE`. It is combinational from registered state.
  - Pushes are accepted in IDLE and RUN, so upstream can prefill the FIFO before `start`.
- IDLE
  - Divider is held at 0 and `pix_en` stays 0.
  - `start` moves the block to RUN and clears `frame_done`, `underflow`, the divider and the coordinate counters. The FIFO contents are kept.
- RUN
  - Divider counts 0..DIV-1 and wraps. A tick occurs on the cycle where divider == DIV-1.
  - On a tick with count > 0: pop the head into `pix_data`.
  - On a tick with count == 0: `pix_data` <= 0 and `underflow` <= 1. The pixel slot is still consumed.
  - A push in the same cycle as an empty-FIFO tick is stored, not forwarded.
- Coordinates
  - `pix_x` and `pix_y` register the coordinate of the pixel loaded on that tick. The first tick of a frame is (0,0).
  - Internal next-coordinate counter: x increments and wraps from imageWidth-1 to 0; on that wrap y increments.
  - The tick that loads (imageWidth-1, imageheight-1) moves the block to DONE and sets `frame_done` <= 1 on the same edge.
- DONE
  - `in_ready` = 0. Outputs are held.
  - `start` re-enters RUN exactly as from IDLE. Leftover FIFO contents are kept.
- `start` during RUN is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push while full is impossible because `in_ready` = 0.

## Timing
- Reset values:
  - `in_ready`: 1 (derived from the empty FIFO).
  - `pix_en`, `frame_done`, `underflow`: 0.
  - `pix_data`, `pix_x`, `pix_y`: 0.
  - count, pointers, divider: 0. State: IDLE.
- First tick is DIV cycles after the `start` edge. `pix_en` is a registered output, high in the cycle after the tick edge, together with the new `pix_data`, `pix_x` and `pix_y`.
- Strobe period is exactly DIV clocks. A frame is imageWidth*imageheight strobes, the last one DIV*W*H clocks after `start`.
- `frame_done` rises in the same cycle as the last `pix_en`.
- A pushed pixel can be popped no earlier than the next edge. Push-to-visible latency is 1 cycle at minimum.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronously) and the FIFO is emptied.
  - After release the block waits in IDLE for `start`.

## Test plan
- **Prefill and frame:** DIV=4, 4x3 image. Push 12 pixels 0x10..0x1B in IDLE, then pulse `start`.
  - `pix_en` pulses every 4 clocks; the first strobe is 5 cycles after `start` (last tick 4 cycles after it).
  - `pix_data` is 0x10..0x1B with (x,y) running (0,0)..(3,2).
  - `frame_done`=1 with the 12th strobe; `underflow`=0.
- **Full FIFO:** FIFO_DEPTH=4, `in_valid` held high in IDLE.
  - Exactly 4 pixels are accepted, then `in_ready`=0.
  - After `start`, the first pop re-raises `in_ready` the next cycle.
- **Underflow:** `start` with an empty FIFO.
  - First strobe shows `pix_data`=0 and `underflow`=1.
  - Pixels pushed afterwards appear from the next strobe on; x/y still advance every strobe.
- **Boundary pushes:** push on the exact tick cycle with count==0, and push+pop with count==FIFO_DEPTH.
  - Count follows the rules above: no pixel lost, no pixel duplicated.
- **Reset mid-frame:** drop `reset` after 5 strobes.
  - All outputs read 0 in the same cycle and `in_ready`=1.
  - A re-prefilled FIFO plus `start` replays the frame from (0,0).
- **Restart from DONE:** `start` pulsed in RUN is ignored (same timing as the first test). After DONE, a second `start` clears `frame_done` and emits a second frame.
